// File: rtl/adf4159_pkg.sv
// Shared constants for the ADF4159 register sequencer: table size, quick-update
// entry point, forced register-address field per table slot, and FSM states.
package adf4159_pkg;

  localparam int         NUM_WORDS   = 11;
  localparam logic [3:0] QUICK_FIRST = 4'd9;
  localparam logic [3:0] LAST_IDX    = 4'(NUM_WORDS - 1);

  // Device write order is R7, R6 x2, R5 x2, R4 x2, R3, R2, R1, R0.
  localparam logic [2:0] ADDR [NUM_WORDS] = '{
    3'd7, 3'd6, 3'd6, 3'd5, 3'd5, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_GAP,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/edge_rise_det.sv
// Rising-edge detector: one history flop and an AND gate.
module edge_rise_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic level_i,
  output logic rise_o
);

  logic prev_q;

  // NOTE: clocked state is always updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prev_q <= 1'b0;
    else         prev_q <= level_i;
  end

  assign rise_o = level_i & ~prev_q;

endmodule

// File: rtl/adf4159_reg_sequencer.sv
// Walks the local table of ADF4159 programming words and hands them, one at a
// time, to the serializer with a fixed gap and a per-word completion timeout.
module adf4159_reg_sequencer
  import adf4159_pkg::*;
#(
  parameter int GAP_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cfg_we_i,
  input  logic [3:0]  cfg_addr_i,
  input  logic [31:0] cfg_data_i,
  input  logic        program_i,
  input  logic        update_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic        start_transfer_o,
  output logic [31:0] data_o,
  input  logic        complete_transfer_i
);

  localparam int          GW   = $clog2(GAP_CYCLES) + 1;
  localparam int          TW   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [GW-1:0] GMAX = GW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  state_e        state_q;
  logic [3:0]    idx_q;
  logic [GW-1:0] gap_q;
  logic [TW-1:0] tmr_q;
  logic          busy_q, done_q, error_q, start_q;
  logic [31:0]   data_q;
  logic [31:3]   table_q [NUM_WORDS];
  logic          rise;

  // The low three bits are replaced by the forced address and never stored.
  logic unused_cfg_low;
  assign unused_cfg_low = ^cfg_data_i[2:0];

  edge_rise_det u_edge (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .level_i (complete_transfer_i),
    .rise_o  (rise)
  );

  // NOTE: the word table is intentionally not reset; it is plain storage that the
  // host must fill before requesting a sequence.
  always_ff @(posedge clk_i) begin
    if (cfg_we_i && !busy_q && (cfg_addr_i < 4'(NUM_WORDS)))
      table_q[cfg_addr_i] <= cfg_data_i[31:3];
  end

  function automatic logic [31:0] word_at(input logic [3:0] i);
    return {table_q[i], ADDR[i]};
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      tmr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      start_q <= 1'b0;
      data_q  <= '0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (program_i || update_i) begin
            idx_q   <= program_i ? 4'd0 : QUICK_FIRST;
            data_q  <= word_at(program_i ? 4'd0 : QUICK_FIRST);
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            error_q <= 1'b0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          tmr_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // An edge coinciding with the timeout limit still counts as success.
          if (rise) begin
            if (idx_q == LAST_IDX) begin
              done_q  <= 1'b1;
              state_q <= ST_FINISH;
            end else begin
              gap_q   <= '0;
              state_q <= ST_GAP;
            end
          end else if (tmr_q == TMAX) begin
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_q == GMAX) begin
            idx_q   <= idx_q + 4'd1;
            data_q  <= word_at(idx_q + 4'd1);
            start_q <= 1'b1;
            state_q <= ST_START;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        ST_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign error_o          = error_q;
  assign start_transfer_o = start_q;
  assign data_o           = data_q;

endmodule
